i2c_target: RTL



---
 rtl/i2c_target.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target (slave) responder. Oversamples SCL/SDA on clk_sys, decodes
// START/STOP and the 7-bit address, streams written bytes out on rx_*,
// and fetches read bytes from a valid/ready source on tx_*. SDA is driven
// open-drain through sda_oe; the block never stretches the clock.
module i2c_target #(
    parameter logic [6:0] OWN_ADDRESS = 7'h3C,
    parameter int         SYNC_STAGES = 2      // at least 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       tx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       stop_det
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_MACK  = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclHist_q;
    logic                   sdaHist_q;

    logic sclS, sdaS;
    logic sclRise, sclFall, sdaRise, sdaFall;
    logic startSeen, stopSeen;

    logic [2:0] state_q,    state_d;
    logic [3:0] bitCnt_q,   bitCnt_d;
    logic [7:0] shift_q,    shift_d;
    logic       rw_q,       rw_d;
    logic [7:0] txBuf_q,    txBuf_d;
    logic       txLoaded_q, txLoaded_d;
    logic       sdaOe_q,    sdaOe_d;
    logic       busy_q,     busy_d;
    logic       rxValid_q,  rxValid_d;
    logic [7:0] rxData_q,   rxData_d;
    logic       txReady_q,  txReady_d;
    logic       stopDet_q,  stopDet_d;

    logic       doLoad;
    logic [7:0] byteNow;

    // Synchronize the pins and keep one history flop per line; reset to the idle-bus level
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclHist_q <= 1'b1;
            sdaHist_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
            sclHist_q <= sclSync_q[SYNC_STAGES-1];
            sdaHist_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclS      = sclSync_q[SYNC_STAGES-1];
    assign sdaS      = sdaSync_q[SYNC_STAGES-1];
    assign sclRise   = sclS & ~sclHist_q;
    assign sclFall   = ~sclS & sclHist_q;
    assign sdaRise   = sdaS & ~sdaHist_q;
    assign sdaFall   = ~sdaS & sdaHist_q;
    assign startSeen = sdaFall & sclS;
    assign stopSeen  = sdaRise & sclS;

    // Byte to shift out when a read byte starts: buffered, handshaking now, or all-ones
    assign byteNow = txLoaded_q ? txBuf_q :
                     ((txReady_q && tx_valid) ? tx_data : 8'hFF);

    // Protocol FSM: per-state actions first, then START/STOP override everything
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        txBuf_d    = txBuf_q;
        txLoaded_d = txLoaded_q;
        sdaOe_d    = sdaOe_q;
        busy_d     = busy_q;
        rxValid_d  = 1'b0;
        rxData_d   = rxData_q;
        txReady_d  = txReady_q;
        stopDet_d  = 1'b0;
        doLoad     = 1'b0;

        if (txReady_q && tx_valid) begin
            txBuf_d    = tx_data;
            txLoaded_d = 1'b1;
            txReady_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
            end
            ADDR: begin
                if (sclRise && bitCnt_q < 4'd8) begin
                    shift_d  = {shift_q[6:0], sdaS};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        rw_d = sdaS;
                        if (shift_q[6:0] != OWN_ADDRESS) begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end else if (sclFall && bitCnt_q == 4'd8) begin
                    sdaOe_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                if (sclRise && rw_q) begin
                    txReady_d  = 1'b1;
                    txLoaded_d = 1'b0;
                end else if (sclFall) begin
                    bitCnt_d = 4'd0;
                    if (rw_q) begin
                        doLoad  = 1'b1;
                        state_d = RD_DATA;
                    end else begin
                        sdaOe_d = 1'b0;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (sclRise && bitCnt_q < 4'd8) begin
                    shift_d  = {shift_q[6:0], sdaS};
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        rxData_d  = {shift_q[6:0], sdaS};
                        rxValid_d = 1'b1;
                    end
                end else if (sclFall && bitCnt_q == 4'd8) begin
                    sdaOe_d = 1'b1;
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                if (sclFall) begin
                    sdaOe_d  = 1'b0;
                    bitCnt_d = 4'd0;
                    state_d  = WR_DATA;
                end
            end
            RD_DATA: begin
                if (sclFall) begin
                    if (bitCnt_q == 4'd0) begin
                        doLoad = 1'b1;
                    end else if (bitCnt_q < 4'd8) begin
                        sdaOe_d  = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b1};
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else begin
                        sdaOe_d = 1'b0;
                        state_d = RD_MACK;
                    end
                end
            end
            RD_MACK: begin
                if (sclRise) begin
                    if (!sdaS) begin
                        txReady_d  = 1'b1;
                        txLoaded_d = 1'b0;
                        bitCnt_d   = 4'd0;
                        state_d    = RD_DATA;
                    end else begin
                        txReady_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = IGNORE;
                    end
                end
            end
            IGNORE: begin
                sdaOe_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doLoad) begin
            sdaOe_d    = ~byteNow[7];
            shift_d    = {byteNow[6:0], 1'b1};
            bitCnt_d   = 4'd1;
            txReady_d  = 1'b0;
            txLoaded_d = 1'b0;
        end

        if (stopSeen) begin
            state_d    = IDLE;
            bitCnt_d   = 4'd0;
            sdaOe_d    = 1'b0;
            busy_d     = 1'b0;
            txReady_d  = 1'b0;
            txLoaded_d = 1'b0;
            stopDet_d  = 1'b1;
        end else if (startSeen) begin
            state_d    = ADDR;
            bitCnt_d   = 4'd0;
            sdaOe_d    = 1'b0;
            txReady_d  = 1'b0;
            txLoaded_d = 1'b0;
        end
    end

    // Register FSM state and all outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            txBuf_q    <= 8'h00;
            txLoaded_q <= 1'b0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            rxValid_q  <= 1'b0;
            rxData_q   <= 8'h00;
            txReady_q  <= 1'b0;
            stopDet_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            txBuf_q    <= txBuf_d;
            txLoaded_q <= txLoaded_d;
            sdaOe_q    <= sdaOe_d;
            busy_q     <= busy_d;
            rxValid_q  <= rxValid_d;
            rxData_q   <= rxData_d;
            txReady_q  <= txReady_d;
            stopDet_q  <= stopDet_d;
        end
    end

    assign sda_oe   = sdaOe_q;
    assign busy     = busy_q;
    assign rx_valid = rxValid_q;
    assign rx_data  = rxData_q;
    assign tx_ready = txReady_q;
    assign stop_det = stopDet_q;

endmodule
